sram_req_ctrl: RTL
==================

Name: sram_req_ctrl

Overview:
- Initiator and controller for the single-port 64-bit byte-enable SRAM macro.
- Upstream side: valid/ready request port plus a read-response port with ready backpressure.
- Downstream side: drives the SRAM CSel/WrEn/BEn/Addr/WrData pins and captures RdData after the fixed macro latency.
- Optionally sweeps the whole array to zero after reset, so simulation and silicon start from a known state.

Parameters:
- ADDR_WIDTH, 9, SRAM address width.
- DATA_DEPTH, 512, number of SRAM words; must be <= 2**ADDR_WIDTH.
- OUT_REGS, 0, must match the SRAM macro setting. Read latency L = 1+OUT_REGS.
- INIT_ON_RESET, 1, 1 = zero-fill sweep after reset; 0 = go straight to RUN.

Ports:
- Clk_CI  in  1  clock
- Rst_RI  in  1  reset; synchronous, active-high
- ReqValid_SI  in  1  request valid
- ReqReady_SO  out  1  request ready
- ReqWrEn_SI  in  1  1 = write, 0 = read
- ReqBEn_SI  in  8  write byte enables
- ReqAddr_DI  in  ADDR_WIDTH  word address
- ReqWrData_DI  in  64  write data
- RspValid_SO  out  1  read response valid
- RspReady_SI  in  1  read response ready
- RspData_DO  out  64  read data
- Busy_SO  out  1  init sweep in progress
- CSel_SO  out  1  SRAM chip select
- WrEn_SO  out  1  SRAM write enable
- BEn_SO  out  8  SRAM byte enables
- Addr_DO  out  ADDR_WIDTH  SRAM address
- WrData_DO  out  64  SRAM write data
- RdData_DI  in  64  SRAM read data

Behaviour:
- States: INIT and RUN.
  - Reset puts the block in INIT if INIT_ON_RESET=1, else in RUN.
  - Reset also clears the init address counter, the outstanding counter, the response FIFO and the latency pipe.
- Values while Rst_RI=1: CSel_SO=0, ReqReady_SO=0, RspValid_SO=0, Busy_SO=0, RspData_DO=0.
- INIT:
  - Busy_SO=1, ReqReady_SO=0.
  - Each cycle: CSel_SO=1, WrEn_SO=1, BEn_SO=8'hFF, WrData_DO=0, Addr_DO=init counter.
  - Counter runs 0..DATA_DEPTH-1, exactly DATA_DEPTH cycles, then the block moves to RUN.
  - Reset mid-sweep restarts the sweep at address 0.
- RUN:
  - Busy_SO=0.
  - ReqReady_SO = (outstanding < RSP_DEPTH), where RSP_DEPTH = L+2. Ready does not depend on ReqValid_SI, ReqWrEn_SI or RspReady_SI.
  - Accept = ReqValid_SI & ReqReady_SO.
  - In an accept cycle, the SRAM pins are driven combinationally: CSel_SO=1, WrEn_SO=ReqWrEn_SI, BEn_SO=ReqBEn_SI, Addr_DO=ReqAddr_DI, WrData_DO=ReqWrData_DI.
  - In a non-accept cycle: CSel_SO=0. The other SRAM outputs are don't-care; they are held at 0.
- Writes:
  - No response is generated.
  - BEn=0 is legal and leaves memory unchanged.
  - A write never changes the outstanding count.
- Reads:
  - An accepted read (cycle t) enters an L-deep valid shift pipe.
  - At cycle t+L, RdData_DI is written into the response FIFO (depth RSP_DEPTH).
  - RspValid_SO rises at cycle t+L+1 at the earliest.
  - Responses are returned strictly in request order.
- Outstanding counter = reads in the pipe + FIFO entries.
  - +1 on read accept; -1 on RspValid_SO & RspReady_SI.
  - Both in the same cycle: unchanged.
  - Never exceeds RSP_DEPTH, so the FIFO never overflows. Overflow or underflow is an assertion failure.
- Throughput:
  - With RspReady_SI held at 1: one read accepted per cycle with no bubbles.
  - RAW to the same address on consecutive cycles returns the new data, because the macro write precedes the next read.
- RspData_DO is the FIFO head. It holds its value while RspValid_SO=1 and RspReady_SI=0.
- Reset mid-operation: in-flight reads and buffered responses are discarded. No RspValid_SO appears for pre-reset requests.

Test Plan:
- Zero-fill sweep: release reset with INIT_ON_RESET=1, DATA_DEPTH=512.
  - Busy_SO=1 for exactly 512 cycles.
  - Addr_DO steps 0..511 with WrEn_SO=1, BEn_SO=FF, WrData_DO=0.
  - ReqReady_SO=1 on cycle 513.
- Full write then read (OUT_REGS=0): write addr 5, 0x1122334455667788, BEn FF; then read addr 5 at cycle t.
  - RspValid_SO at t+2 with that data.
  - With OUT_REGS=1: RspValid_SO at t+3.
- Partial write: write 0xAAAAAAAAAAAAAAAA, BEn 0F, to addr 5; then read -> 0x11223344AAAAAAAA. Read of unwritten addr 9 -> 0.
- Streaming reads: 8 back-to-back reads of addrs 0..7 with RspReady_SI=1.
  - ReqReady_SO never drops.
  - 8 consecutive responses, in order.
- Backpressure (OUT_REGS=0, RSP_DEPTH=3): RspReady_SI=0, ReqValid_SI=1 reads.
  - Exactly 3 accepts, then ReqReady_SO=0. Writes also stall.
  - Raising RspReady_SI drains 3 in-order responses, and ReqReady_SO returns the cycle after the first pop.
- Reset cases:
  - Assert Rst_RI during the sweep at addr 100 -> sweep restarts at 0 and lasts a full 512 cycles.
  - Assert Rst_RI with 2 reads in flight -> no RspValid_SO afterwards; counter = 0.

Source files
------------

// File: rtl/sram_req_ctrl_if.sv
// sram_req_ctrl_if: bundles the upstream request/response handshake, the
// Busy flag and the SRAM macro pin group of sram_req_ctrl.
//
// Signals:
//   ReqValid_SI/ReqReady_SO        request handshake
//   ReqWrEn_SI, ReqBEn_SI          request type and write byte enables
//   ReqAddr_DI, ReqWrData_DI       request word address and write data
//   RspValid_SO/RspReady_SI        read response handshake
//   RspData_DO                     read response data (FIFO head)
//   Busy_SO                        zero-fill sweep in progress
//   CSel_SO, WrEn_SO, BEn_SO       SRAM chip select, write enable, byte enables
//   Addr_DO, WrData_DO             SRAM address and write data
//   RdData_DI                      SRAM read data
//
// Modports:
//   slave  - controller view (sram_req_ctrl)
//   master - environment view (requester plus SRAM macro)
interface sram_req_ctrl_if #(
  parameter int ADDR_WIDTH = 9
);
  logic                  ReqValid_SI;
  logic                  ReqReady_SO;
  logic                  ReqWrEn_SI;
  logic [7:0]            ReqBEn_SI;
  logic [ADDR_WIDTH-1:0] ReqAddr_DI;
  logic [63:0]           ReqWrData_DI;
  logic                  RspValid_SO;
  logic                  RspReady_SI;
  logic [63:0]           RspData_DO;
  logic                  Busy_SO;
  logic                  CSel_SO;
  logic                  WrEn_SO;
  logic [7:0]            BEn_SO;
  logic [ADDR_WIDTH-1:0] Addr_DO;
  logic [63:0]           WrData_DO;
  logic [63:0]           RdData_DI;

  modport slave (
    input  ReqValid_SI, ReqWrEn_SI, ReqBEn_SI, ReqAddr_DI, ReqWrData_DI,
    input  RspReady_SI, RdData_DI,
    output ReqReady_SO, RspValid_SO, RspData_DO, Busy_SO,
    output CSel_SO, WrEn_SO, BEn_SO, Addr_DO, WrData_DO
  );

  modport master (
    output ReqValid_SI, ReqWrEn_SI, ReqBEn_SI, ReqAddr_DI, ReqWrData_DI,
    output RspReady_SI, RdData_DI,
    input  ReqReady_SO, RspValid_SO, RspData_DO, Busy_SO,
    input  CSel_SO, WrEn_SO, BEn_SO, Addr_DO, WrData_DO
  );
endinterface

// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: initiator/controller for a single-port 64-bit byte-enable
// SRAM macro. Accepts valid/ready requests, drives the macro pins in the
// accept cycle, collects read data after the macro latency into a small
// response FIFO and returns it in order with ready backpressure. An optional
// zero-fill sweep runs after reset.
//
// Ports:
//   Clk_CI  clock
//   Rst_RI  synchronous active-high reset
//   bus     sram_req_ctrl_if.slave (request, response, Busy, SRAM pins)
//
// state   | meaning
// ST_INIT | zero-fill sweep, one word per cycle, requests blocked
// ST_RUN  | normal operation, requests accepted while credits remain
module sram_req_ctrl #(
  parameter int ADDR_WIDTH    = 9,
  parameter int DATA_DEPTH    = 512,
  parameter int OUT_REGS      = 0,
  parameter int INIT_ON_RESET = 1
) (
  input  logic           Clk_CI,
  input  logic           Rst_RI,
  sram_req_ctrl_if.slave bus
);

  localparam int L         = 1 + OUT_REGS;
  localparam int RSP_DEPTH = L + 2;
  localparam int PW        = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW        = $clog2(RSP_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);
  localparam logic [PW-1:0]         LAST_PTR  = PW'(RSP_DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;
  localparam state_e RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;
  logic [L-1:0]          pipe_q, pipe_d;
  logic [CW-1:0]         out_q, out_d;
  logic [CW-1:0]         fcnt_q, fcnt_d;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [63:0]           fifo_q [RSP_DEPTH];
  logic [63:0]           fifo_d [RSP_DEPTH];

  logic req_ready, accept, rd_acc, push, rsp_valid, pop;

  logic                  sram_csel, sram_wren;
  logic [7:0]            sram_ben;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [63:0]           sram_wdata;

  // Credit scheme: every read in the latency pipe or the FIFO holds one
  // credit, so the FIFO cannot overflow and RspReady_SI never blocks a push.
  always_comb begin
    req_ready = !Rst_RI && (state_q == ST_RUN) && (out_q < CW'(RSP_DEPTH));
    accept    = bus.ReqValid_SI && req_ready;
    rd_acc    = accept && !bus.ReqWrEn_SI;
    push      = pipe_q[L-1];
    rsp_valid = !Rst_RI && (fcnt_q != '0);
    pop       = rsp_valid && bus.RspReady_SI;
  end

  always_comb begin
    sram_csel  = 1'b0;
    sram_wren  = 1'b0;
    sram_ben   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (!Rst_RI) begin
      if (state_q == ST_INIT) begin
        sram_csel = 1'b1;
        sram_wren = 1'b1;
        sram_ben  = 8'hFF;
        sram_addr = init_addr_q;
      end else if (accept) begin
        sram_csel  = 1'b1;
        sram_wren  = bus.ReqWrEn_SI;
        sram_ben   = bus.ReqBEn_SI;
        sram_addr  = bus.ReqAddr_DI;
        sram_wdata = bus.ReqWrData_DI;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (state_q == ST_INIT) begin
      init_addr_d = init_addr_q + ADDR_WIDTH'(1);
      if (init_addr_q == LAST_ADDR) begin
        state_d = ST_RUN;
      end
    end

    pipe_d[0] = rd_acc;
    for (int i = 1; i < L; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    fifo_d = fifo_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      fifo_d[wptr_q] = bus.RdData_DI;
      wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PW'(1);
    end

    fcnt_d = fcnt_q;
    if (push && !pop) begin
      fcnt_d = fcnt_q + CW'(1);
    end else if (pop && !push) begin
      fcnt_d = fcnt_q - CW'(1);
    end

    out_d = out_q;
    if (rd_acc && !pop) begin
      out_d = out_q + CW'(1);
    end else if (pop && !rd_acc) begin
      out_d = out_q - CW'(1);
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q     <= RESET_STATE;
      init_addr_q <= '0;
      pipe_q      <= '0;
      out_q       <= '0;
      fcnt_q      <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      fifo_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      pipe_q      <= pipe_d;
      out_q       <= out_d;
      fcnt_q      <= fcnt_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      fifo_q      <= fifo_d;
    end
  end

  assign bus.ReqReady_SO = req_ready;
  assign bus.RspValid_SO = rsp_valid;
  assign bus.RspData_DO  = Rst_RI ? '0 : fifo_q[rptr_q];
  assign bus.Busy_SO     = !Rst_RI && (state_q == ST_INIT);
  assign bus.CSel_SO     = sram_csel;
  assign bus.WrEn_SO     = sram_wren;
  assign bus.BEn_SO      = sram_ben;
  assign bus.Addr_DO     = sram_addr;
  assign bus.WrData_DO   = sram_wdata;

  credit_overflow: assert property (@(posedge Clk_CI) disable iff (Rst_RI)
    !(rd_acc && !pop && (out_q == CW'(RSP_DEPTH))));
  credit_underflow: assert property (@(posedge Clk_CI) disable iff (Rst_RI)
    !(pop && !rd_acc && (out_q == '0)));
  fifo_overflow: assert property (@(posedge Clk_CI) disable iff (Rst_RI)
    !(push && !pop && (fcnt_q == CW'(RSP_DEPTH))));

endmodule
